// File: rtl/freq_peak_detect_if.sv
// Streaming bus between an FFT frame source and the peak detector.
//   sink_valid/sop/eop  beat qualifier and frame delimiters
//   sink_re/sink_im     signed complex bin sample
//   peak_*/frame_len    per-frame result, qualified by peak_valid
//   err_valid/err_code  frame error pulse and sticky error code
// master: the side that produces beats and consumes results.
// slave:  the detector.
interface freq_peak_detect_if #(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned TOT_SIZE   = 2048
);
    localparam int unsigned BinW = $clog2(TOT_SIZE);

    logic                           sink_valid;
    logic                           sink_sop;
    logic                           sink_eop;
    logic signed [DATA_WIDTH-1:0]   sink_re;
    logic signed [DATA_WIDTH-1:0]   sink_im;

    logic                           peak_valid;
    logic        [BinW-1:0]         peak_bin;
    logic        [2*DATA_WIDTH-1:0] peak_pow;
    logic        [BinW:0]           frame_len;
    logic                           err_valid;
    logic        [1:0]              err_code;

    modport master (
        output sink_valid, sink_sop, sink_eop, sink_re, sink_im,
        input  peak_valid, peak_bin, peak_pow, frame_len, err_valid, err_code
    );

    modport slave (
        input  sink_valid, sink_sop, sink_eop, sink_re, sink_im,
        output peak_valid, peak_bin, peak_pow, frame_len, err_valid, err_code
    );
endinterface

// File: rtl/freq_peak_detect.sv
// Frequency peak detector: watches an FFT output frame stream, computes per-bin
// power re^2+im^2 and reports the strongest eligible bin of every frame.
// Ports:
//   sink_clk      clock, rising edge
//   sink_reset_n  asynchronous active-low reset
//   bus           freq_peak_detect_if slave (input beats in, results/errors out)
// Pipeline: edge N registers the beat, N+1 the squares, N+2 the sum, running
// max and the result/error outputs. Malformed frames (sop restart, overlength)
// raise err_valid and are never reported.
module freq_peak_detect #(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned TOT_SIZE   = 2048,
    parameter int unsigned MIN_BIN    = 1
) (
    input logic               sink_clk,
    input logic               sink_reset_n,
    freq_peak_detect_if.slave bus
);
    localparam int unsigned BinW = $clog2(TOT_SIZE);
    localparam int unsigned LenW = BinW + 1;
    localparam int unsigned PowW = 2 * DATA_WIDTH;
    localparam int unsigned SqW  = PowW - 1;
    localparam logic [BinW-1:0] LastBin = BinW'(TOT_SIZE - 1);

    typedef enum logic [0:0] {StIdle, StInFrame} state_e;

    state_e          state_q, state_d;
    logic [BinW-1:0] cnt_q, cnt_d;   // index the next in-frame beat will get
    logic            over_q, over_d; // last accepted beat sat at LastBin

    // Decoded beat, valid only in the cycle the beat is presented
    logic            beat_acc;
    logic            beat_first;
    logic            beat_last;
    logic            beat_err_rst;
    logic            beat_err_over;
    logic [BinW-1:0] beat_bin;

    // ---------------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge sink_clk or negedge sink_reset_n) begin
        if (!sink_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.sink_valid) begin
            case (state_q)
                StIdle: begin
                    if (bus.sink_sop) begin
                        state_d = bus.sink_eop ? StIdle : StInFrame;
                    end
                end
                StInFrame: begin
                    if (bus.sink_sop) begin
                        state_d = bus.sink_eop ? StIdle : StInFrame;
                    end else if (over_q || bus.sink_eop) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        beat_acc      = 1'b0;
        beat_first    = 1'b0;
        beat_last     = 1'b0;
        beat_err_rst  = 1'b0;
        beat_err_over = 1'b0;
        beat_bin      = '0;
        cnt_d         = cnt_q;
        over_d        = over_q;
        if (bus.sink_valid) begin
            if (bus.sink_sop) begin
                // A sop always opens a fresh frame; it is only an error if it
                // cuts into a frame that still had room to continue.
                beat_acc     = 1'b1;
                beat_first   = 1'b1;
                beat_last    = bus.sink_eop;
                beat_err_rst = (state_q == StInFrame) && !over_q;
                cnt_d        = BinW'(1);
                over_d       = 1'b0;
            end else if (state_q == StInFrame) begin
                if (over_q) begin
                    beat_err_over = 1'b1;
                    over_d        = 1'b0;
                end else begin
                    beat_acc  = 1'b1;
                    beat_last = bus.sink_eop;
                    beat_bin  = cnt_q;
                    cnt_d     = cnt_q + BinW'(1);
                    over_d    = !bus.sink_eop && (cnt_q == LastBin);
                end
            end
        end
    end

    always_ff @(posedge sink_clk or negedge sink_reset_n) begin
        if (!sink_reset_n) begin
            cnt_q  <= '0;
            over_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            over_q <= over_d;
        end
    end

    // ---------------------------------------------------------------------
    // Stage 0: registered beat
    // ---------------------------------------------------------------------
    logic                         s0_valid_q;
    logic                         s0_first_q;
    logic                         s0_last_q;
    logic [1:0]                   s0_err_q;
    logic [BinW-1:0]              s0_bin_q;
    logic signed [DATA_WIDTH-1:0] s0_re_q;
    logic signed [DATA_WIDTH-1:0] s0_im_q;

    always_ff @(posedge sink_clk or negedge sink_reset_n) begin
        if (!sink_reset_n) begin
            s0_valid_q <= 1'b0;
            s0_first_q <= 1'b0;
            s0_last_q  <= 1'b0;
            s0_err_q   <= 2'b00;
            s0_bin_q   <= '0;
            s0_re_q    <= '0;
            s0_im_q    <= '0;
        end else begin
            s0_valid_q <= beat_acc;
            s0_first_q <= beat_first;
            s0_last_q  <= beat_last;
            s0_err_q   <= {beat_err_over, beat_err_rst};
            s0_bin_q   <= beat_bin;
            s0_re_q    <= bus.sink_re;
            s0_im_q    <= bus.sink_im;
        end
    end

    // ---------------------------------------------------------------------
    // Stage 1: squares
    // ---------------------------------------------------------------------
    // Sign-extend to SqW so the product is formed at SqW bits; the true square
    // never exceeds 2^(SqW-1), so the low SqW bits read as unsigned are exact.
    logic signed [SqW-1:0] re_ext;
    logic signed [SqW-1:0] im_ext;
    logic        [SqW-1:0] sq_re_d;
    logic        [SqW-1:0] sq_im_d;

    always_comb begin
        re_ext  = {{(DATA_WIDTH-1){s0_re_q[DATA_WIDTH-1]}}, s0_re_q};
        im_ext  = {{(DATA_WIDTH-1){s0_im_q[DATA_WIDTH-1]}}, s0_im_q};
        sq_re_d = re_ext * re_ext;
        sq_im_d = im_ext * im_ext;
    end

    logic            s1_valid_q;
    logic            s1_first_q;
    logic            s1_last_q;
    logic [1:0]      s1_err_q;
    logic [BinW-1:0] s1_bin_q;
    logic [SqW-1:0]  sq_re_q;
    logic [SqW-1:0]  sq_im_q;

    always_ff @(posedge sink_clk or negedge sink_reset_n) begin
        if (!sink_reset_n) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_err_q   <= 2'b00;
            s1_bin_q   <= '0;
            sq_re_q    <= '0;
            sq_im_q    <= '0;
        end else begin
            s1_valid_q <= s0_valid_q;
            s1_first_q <= s0_first_q;
            s1_last_q  <= s0_last_q;
            s1_err_q   <= s0_err_q;
            s1_bin_q   <= s0_bin_q;
            sq_re_q    <= sq_re_d;
            sq_im_q    <= sq_im_d;
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: power, running max, results
    // ---------------------------------------------------------------------
    logic eligible;

    if (MIN_BIN == 0) begin : g_all_bins
        assign eligible = 1'b1;
    end else begin : g_min_bin
        assign eligible = (s1_bin_q >= BinW'(MIN_BIN));
    end

    logic            have_q, have_d;     // an eligible bin has been seen
    logic [PowW-1:0] max_pow_q, max_pow_d;
    logic [BinW-1:0] max_bin_q, max_bin_d;

    logic            peak_valid_q, peak_valid_d;
    logic [BinW-1:0] peak_bin_q, peak_bin_d;
    logic [PowW-1:0] peak_pow_q, peak_pow_d;
    logic [LenW-1:0] frame_len_q, frame_len_d;
    logic            err_valid_q, err_valid_d;
    logic [1:0]      err_code_q, err_code_d;

    logic [PowW-1:0] pow_sum;
    logic            base_have;
    logic [PowW-1:0] base_pow;
    logic [BinW-1:0] base_bin;
    logic            take;

    always_comb begin
        pow_sum = {1'b0, sq_re_q} + {1'b0, sq_im_q};

        // The first beat of a frame ignores whatever the previous frame left
        base_have = s1_first_q ? 1'b0 : have_q;
        base_pow  = s1_first_q ? '0 : max_pow_q;
        base_bin  = s1_first_q ? '0 : max_bin_q;

        // Strictly greater keeps the lowest index on ties
        take = s1_valid_q && eligible && (!base_have || (pow_sum > base_pow));

        have_d    = have_q;
        max_pow_d = max_pow_q;
        max_bin_d = max_bin_q;
        if (s1_valid_q) begin
            have_d    = base_have | eligible;
            max_pow_d = take ? pow_sum : base_pow;
            max_bin_d = take ? s1_bin_q : base_bin;
        end

        peak_valid_d = s1_valid_q && s1_last_q;
        peak_bin_d   = peak_bin_q;
        peak_pow_d   = peak_pow_q;
        frame_len_d  = frame_len_q;
        if (peak_valid_d) begin
            peak_bin_d  = have_d ? max_bin_d : '0;
            peak_pow_d  = have_d ? max_pow_d : '0;
            frame_len_d = {1'b0, s1_bin_q} + LenW'(1);
        end

        err_valid_d = |s1_err_q;
        err_code_d  = err_valid_d ? s1_err_q : err_code_q;
    end

    always_ff @(posedge sink_clk or negedge sink_reset_n) begin
        if (!sink_reset_n) begin
            have_q       <= 1'b0;
            max_pow_q    <= '0;
            max_bin_q    <= '0;
            peak_valid_q <= 1'b0;
            peak_bin_q   <= '0;
            peak_pow_q   <= '0;
            frame_len_q  <= '0;
            err_valid_q  <= 1'b0;
            err_code_q   <= 2'b00;
        end else begin
            have_q       <= have_d;
            max_pow_q    <= max_pow_d;
            max_bin_q    <= max_bin_d;
            peak_valid_q <= peak_valid_d;
            peak_bin_q   <= peak_bin_d;
            peak_pow_q   <= peak_pow_d;
            frame_len_q  <= frame_len_d;
            err_valid_q  <= err_valid_d;
            err_code_q   <= err_code_d;
        end
    end

    assign bus.peak_valid = peak_valid_q;
    assign bus.peak_bin   = peak_bin_q;
    assign bus.peak_pow   = peak_pow_q;
    assign bus.frame_len  = frame_len_q;
    assign bus.err_valid  = err_valid_q;
    assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_freq_peak_detect.sv
// Scoreboard bench for freq_peak_detect. dut_a: TOT_SIZE=16, MIN_BIN=1;
// dut_b: TOT_SIZE=16, MIN_BIN=0 (full-scale single-bin frame only).
module tb_freq_peak_detect;
    localparam int DW = 20;
    localparam int TS = 16;
    localparam int BW = $clog2(TS);

    logic sink_clk = 1'b0;
    logic sink_reset_n = 1'b0;

    always #5 sink_clk = ~sink_clk;

    freq_peak_detect_if #(.DATA_WIDTH(DW), .TOT_SIZE(TS)) ifa ();
    freq_peak_detect_if #(.DATA_WIDTH(DW), .TOT_SIZE(TS)) ifb ();

    freq_peak_detect #(.DATA_WIDTH(DW), .TOT_SIZE(TS), .MIN_BIN(1)) dut_a (
        .sink_clk     (sink_clk),
        .sink_reset_n (sink_reset_n),
        .bus          (ifa)
    );

    freq_peak_detect #(.DATA_WIDTH(DW), .TOT_SIZE(TS), .MIN_BIN(0)) dut_b (
        .sink_clk     (sink_clk),
        .sink_reset_n (sink_reset_n),
        .bus          (ifb)
    );

    typedef struct {
        bit     is_err;
        int     bin;
        longint pow;
        int     len;
        int     code;
        int     cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge sink_clk) cyc <= cyc + 1;

    function automatic void chk(string name, longint act, longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void got(bit sel, bit is_err, logic [BW-1:0] bin, logic [2*DW-1:0] pow,
                                logic [BW:0] len, logic [1:0] code);
        exp_t  e;
        string tag;
        int    depth;
        tag   = {sel ? "b" : "a", is_err ? "_err" : "_peak"};
        depth = sel ? qb.size() : qa.size();
        if (depth == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_unexpected: got event at cycle %0d, expected none", tag, cyc);
        end else begin
            if (sel) e = qb.pop_front();
            else     e = qa.pop_front();
            chk({tag, "_kind"}, longint'(is_err), longint'(e.is_err));
            chk({tag, "_cycle"}, longint'(cyc), longint'(e.cyc));
            if (e.is_err) begin
                chk({tag, "_code"}, longint'(code), longint'(e.code));
            end else begin
                chk({tag, "_bin"}, longint'(bin), longint'(e.bin));
                chk({tag, "_pow"}, longint'(pow), e.pow);
                chk({tag, "_len"}, longint'(len), longint'(e.len));
            end
        end
    endfunction

    // Monitor: errors are consumed before reports within one cycle
    always @(negedge sink_clk) begin
        if (sink_reset_n) begin
            if (ifa.err_valid)
                got(1'b0, 1'b1, ifa.peak_bin, ifa.peak_pow, ifa.frame_len, ifa.err_code);
            if (ifa.peak_valid)
                got(1'b0, 1'b0, ifa.peak_bin, ifa.peak_pow, ifa.frame_len, ifa.err_code);
            if (ifb.err_valid)
                got(1'b1, 1'b1, ifb.peak_bin, ifb.peak_pow, ifb.frame_len, ifb.err_code);
            if (ifb.peak_valid)
                got(1'b1, 1'b0, ifb.peak_bin, ifb.peak_pow, ifb.frame_len, ifb.err_code);
        end
    end

    // Called at a negedge just before the beat is driven; the beat is sampled
    // on edge cyc+1 and the result appears two edges later.
    task automatic exp_peak(input bit sel, input int bin, input longint pow, input int len);
        exp_t e;
        e.is_err = 1'b0;
        e.bin    = bin;
        e.pow    = pow;
        e.len    = len;
        e.code   = 0;
        e.cyc    = cyc + 3;
        if (sel) qb.push_back(e);
        else     qa.push_back(e);
    endtask

    task automatic exp_err(input bit sel, input int code);
        exp_t e;
        e.is_err = 1'b1;
        e.bin    = 0;
        e.pow    = 0;
        e.len    = 0;
        e.code   = code;
        e.cyc    = cyc + 3;
        if (sel) qb.push_back(e);
        else     qa.push_back(e);
    endtask

    task automatic beat(input bit sel, input bit sop, input bit eop, input int re, input int im);
        ifa.sink_sop   = sop;
        ifa.sink_eop   = eop;
        ifa.sink_re    = DW'(re);
        ifa.sink_im    = DW'(im);
        ifb.sink_sop   = sop;
        ifb.sink_eop   = eop;
        ifb.sink_re    = DW'(re);
        ifb.sink_im    = DW'(im);
        ifa.sink_valid = !sel;
        ifb.sink_valid = sel;
        @(negedge sink_clk);
        ifa.sink_valid = 1'b0;
        ifb.sink_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sink_clk);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_a_peak_valid"}, longint'(ifa.peak_valid), 0);
        chk({tag, "_a_peak_bin"}, longint'(ifa.peak_bin), 0);
        chk({tag, "_a_peak_pow"}, longint'(ifa.peak_pow), 0);
        chk({tag, "_a_frame_len"}, longint'(ifa.frame_len), 0);
        chk({tag, "_a_err_valid"}, longint'(ifa.err_valid), 0);
        chk({tag, "_a_err_code"}, longint'(ifa.err_code), 0);
        chk({tag, "_b_peak_valid"}, longint'(ifb.peak_valid), 0);
        chk({tag, "_b_peak_pow"}, longint'(ifb.peak_pow), 0);
        chk({tag, "_b_frame_len"}, longint'(ifb.frame_len), 0);
        chk({tag, "_b_err_code"}, longint'(ifb.err_code), 0);
    endtask

    initial begin
        ifa.sink_valid = 1'b0;
        ifa.sink_sop   = 1'b0;
        ifa.sink_eop   = 1'b0;
        ifa.sink_re    = '0;
        ifa.sink_im    = '0;
        ifb.sink_valid = 1'b0;
        ifb.sink_sop   = 1'b0;
        ifb.sink_eop   = 1'b0;
        ifb.sink_re    = '0;
        ifb.sink_im    = '0;

        idle(3);
        rst_chk("reset");
        sink_reset_n = 1'b1;
        idle(2);

        // Stray beats outside a frame are dropped, including a lone eop
        beat(0, 0, 0, 999, 999);
        beat(0, 0, 1, 999, 999);
        idle(2);

        // 8-bin frame, bin5 = 3-4j -> power 25
        for (int i = 0; i < 8; i++) begin
            if (i == 7) exp_peak(0, 5, 25, 8);
            beat(0, i == 0, i == 7, (i == 5) ? 3 : 0, (i == 5) ? -4 : 0);
        end
        // Back-to-back frame: DC excluded, tie at bins 3 and 6 -> bin3
        for (int i = 0; i < 8; i++) begin
            if (i == 7) exp_peak(0, 3, 49, 8);
            beat(0, i == 0, i == 7, (i == 0) ? 1000 : ((i == 3 || i == 6) ? -7 : 0), 0);
        end
        idle(3);

        // Single-bin frames at full negative scale
        exp_peak(0, 0, 0, 1);
        beat(0, 1, 1, -524288, -524288);
        exp_peak(1, 0, longint'(1) << 39, 1);
        beat(1, 1, 1, -524288, -524288);
        idle(3);

        // Restart mid-frame: old frame (with a large bin1) is discarded
        for (int i = 0; i < 4; i++) beat(0, i == 0, 0, (i == 1) ? 100 : 0, 0);
        exp_err(0, 1);
        beat(0, 1, 0, 9, 0);
        beat(0, 0, 0, 2, 0);
        beat(0, 0, 0, 0, 6);
        exp_peak(0, 2, 36, 4);
        beat(0, 0, 1, 1, 0);
        idle(3);
        chk("a_err_code_held", longint'(ifa.err_code), 1);

        // Overlength: 17th beat without sop -> error, no report
        for (int i = 0; i < 16; i++) beat(0, i == 0, 0, (i == 3) ? 500 : 0, 0);
        exp_err(0, 2);
        beat(0, 0, 0, 700, 0);
        beat(0, 1, 0, 0, 0);
        beat(0, 0, 0, -2, -2);
        beat(0, 0, 0, 2, 2);
        exp_peak(0, 1, 8, 4);
        beat(0, 0, 1, 0, 0);
        idle(3);

        // Full frame without eop, then sop on the would-be 17th beat: clean start
        for (int i = 0; i < 16; i++) beat(0, i == 0, 0, 0, 0);
        beat(0, 1, 0, 0, 0);
        beat(0, 0, 0, 3, 0);
        beat(0, 0, 0, 0, 0);
        exp_peak(0, 1, 9, 4);
        beat(0, 0, 1, 0, -3);
        idle(3);

        // eop exactly at the last bin is legal
        for (int i = 0; i < 16; i++) begin
            if (i == 15) exp_peak(0, 15, 225, 16);
            beat(0, i == 0, i == 15, i, 0);
        end
        idle(4);

        // Reset mid-frame at bin 10: no report, outputs cleared
        for (int i = 0; i < 11; i++) beat(0, i == 0, 0, (i == 4) ? 50 : 0, 0);
        sink_reset_n = 1'b0;
        #1;
        rst_chk("midreset");
        @(negedge sink_clk);
        sink_reset_n = 1'b1;
        @(negedge sink_clk);
        beat(0, 1, 0, 0, 0);
        beat(0, 0, 0, 1, 1);
        beat(0, 0, 0, -1, 1);
        exp_peak(0, 3, 16, 4);
        beat(0, 0, 1, 0, 4);

        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) begin
            @(negedge sink_clk);
        end
        idle(2);
        chk("a_pending_expectations", longint'(qa.size()), 0);
        chk("b_pending_expectations", longint'(qb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/freq_peak_detect.md
Name: freq_peak_detect

Overview:
- Streaming consumer of the FFT output frame stream, in parallel with the frequency buffer on the same sop/eop/valid/re/im bus.
- Computes per-bin power re^2+im^2 and tracks the strongest bin in each frame.
- At frame end, reports the peak bin index, its power and the frame length.
- Flags malformed frames: restart mid-frame or overlength.

Parameters:
- DATA_WIDTH, 20, bits per real/imag sample (signed two's complement).
- TOT_SIZE, 2048, maximum bins per frame.
- MIN_BIN, 1, lowest bin index eligible for the peak search (1 excludes DC).

Ports:
- sink_clk  in  1  clock, all logic on rising edge.
- sink_reset_n  in  1  asynchronous active-low reset.
- sink_valid  in  1  high: input beat valid.
- sink_sop  in  1  high: first bin of frame (qualified by sink_valid).
- sink_eop  in  1  high: last bin of frame (qualified by sink_valid).
- sink_re  in  DATA_WIDTH  real sample, signed.
- sink_im  in  DATA_WIDTH  imaginary sample, signed.
- peak_valid  out  1  one-cycle pulse: result fields valid.
- peak_bin  out  $clog2(TOT_SIZE)  index of strongest eligible bin.
- peak_pow  out  2*DATA_WIDTH  unsigned power of that bin.
- frame_len  out  $clog2(TOT_SIZE)+1  number of bins in the reported frame.
- err_valid  out  1  one-cycle pulse: frame error.
- err_code  out  2  01 = sop restart mid-frame; 10 = overlength frame; held until the next err_valid.

Behaviour:
- Reset: asynchronous, active-low. All outputs to 0. FSM to IDLE. Bin counter and running max cleared. Any frame in progress is discarded with no report. Release is synchronous to sink_clk.
- No backpressure. A beat is accepted on every edge where sink_valid=1.
- FSM states: IDLE, IN_FRAME.
  - IDLE, valid & sop: bin 0, go to IN_FRAME (or stay IDLE and report if eop is also set).
  - IDLE, valid & !sop: beat dropped, no count.
  - IN_FRAME, valid & !sop: bin index +1.
  - IN_FRAME, valid & eop: schedule report, go to IDLE.
- sop while IN_FRAME: err_valid with err_code=01. The old frame is discarded. The new frame starts at bin 0 on that beat.
- sop & eop on the same beat: one-bin frame, frame_len=1, reported normally.
- Overlength: a valid non-eop beat at bin TOT_SIZE-1 means the next beat would exceed capacity. On the next valid non-sop beat: err_valid with err_code=10, frame discarded, go to IDLE. A sop on that beat instead starts a new frame cleanly with no error. An eop exactly at bin TOT_SIZE-1 is legal: frame_len=TOT_SIZE.
- Arithmetic:
  - Squares are signed*signed, each 2*DATA_WIDTH-1 bits unsigned.
  - Sum is 2*DATA_WIDTH bits and cannot overflow. Max is 2^(2*DATA_WIDTH-1) at re=im=-2^(DATA_WIDTH-1).
- Pipeline:
  - Edge N samples the beat.
  - Edge N+1 registers re^2, im^2, bin index and flags.
  - Edge N+2 registers the sum and updates the running max.
- Peak rule:
  - Only bins with index >= MIN_BIN compete.
  - The first eligible bin of a frame always loads the running max.
  - Later bins replace it only if strictly greater, so on ties the lowest index wins.
  - If no bin is eligible, report peak_bin=0, peak_pow=0.
- Report timing: eop beat sampled at edge N. peak_valid is high for exactly one cycle, from edge N+2 to N+3. peak_bin, peak_pow and frame_len are registered at edge N+2 and held until the next report.
- Error timing: err_valid is high for one cycle, two edges after the offending beat. This aligns with the pipeline.
- Back-to-back frames: a sop on edge N+1 after an eop on edge N is legal. The running max re-initialises from the sop beat in stage 2 without disturbing the pending report. Both frames are reported.
- peak_valid and err_valid are never high in the same cycle for the same frame. A restart error and a report of a different frame may coincide.

Test Plan:
- Single frame of 8 bins (sop bin0, eop bin7) with re=0,im=0 except bin5 re=3,im=-4 → peak_valid 2 cycles after eop; peak_bin=5, peak_pow=25, frame_len=8.
- Same frame, bin0 re=1000, bin3 and bin6 both re=-7 → DC excluded; peak_bin=3 (tie, lower index), peak_pow=49.
- sop & eop on one beat, re=im=-524288, MIN_BIN=0 → frame_len=1, peak_bin=0, peak_pow=2^39.
- sop at bin0, sop again at beat 4, eop 3 beats later → err_valid err_code=01 two cycles after second sop; then peak_valid with frame_len=4.
- TOT_SIZE=16, 17 valid beats with no eop → err_valid err_code=10 on beat 17 (+2 cycles); no peak_valid; a following 4-bin frame reports frame_len=4.
- sink_reset_n low mid-frame (bin 10), then a new 4-bin frame → all outputs 0 during reset; no report for the aborted frame; the new frame reports frame_len=4.
